// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter that shares one registered valid/stall pipeline stage among NUM_REQ requesters.
// Optional burst locking is enabled by defining PIPE_RR_ARBITER_BURST_EN.
module pipe_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ID_W    = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_flush,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]        i_req_last,
  output logic [NUM_REQ-1:0]        o_req_stall,
  input  logic                      i_stall,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_valid,
  output logic [ID_W-1:0]           o_grant_id
);

  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic [ID_W-1:0]   grant_q;
  logic [ID_W-1:0]   ptr_q;

  logic              ld;
  logic              rr_any;
  logic [ID_W-1:0]   rr_win;
  int unsigned       rr_idx;
  logic              sel_any;
  logic [ID_W-1:0]   sel_win;
  logic              cap;

  assign ld = (!valid_q || !i_stall) && !i_flush;

  // Search starts one past the last winner and wraps modulo NUM_REQ.
  always_comb begin
    rr_any = 1'b0;
    rr_win = '0;
    rr_idx = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      rr_idx = (32'(ptr_q) + off) % NUM_REQ;
      if (!rr_any && i_req_valid[rr_idx]) begin
        rr_any = 1'b1;
        rr_win = rr_idx[ID_W-1:0];
      end
    end
  end

`ifdef PIPE_RR_ARBITER_BURST_EN
  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    sel_any = rr_any;
    sel_win = rr_win;
    if (state_q == StLocked) begin
      sel_win = owner_q;
      sel_any = i_req_valid[owner_q];
    end
    cap = ld && sel_any;
    if (i_flush) begin
      state_d = StIdle;
    end else if (cap) begin
      if (state_q == StIdle && !i_req_last[sel_win]) begin
        state_d = StLocked;
        owner_d = sel_win;
      end else if (state_q == StLocked && i_req_last[sel_win]) begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
`else
  logic unused_last;

  assign unused_last = ^i_req_last;
  assign sel_any     = rr_any;
  assign sel_win     = rr_win;
  assign cap         = ld && rr_any;
`endif

  always_comb begin
    o_req_stall = '1;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (cap && sel_win == ID_W'(k)) o_req_stall[k] = 1'b0;
    end
  end

  // Flush without a load drops the beat; a plain stall holds everything.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= ID_W'(NUM_REQ - 1);
    end else if (cap) begin
      valid_q <= 1'b1;
      data_q  <= i_req_data[DATA_W * 32'(sel_win) +: DATA_W];
      grant_q <= sel_win;
      ptr_q   <= sel_win;
    end else if (ld || i_flush) begin
      valid_q <= 1'b0;
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_grant_id = grant_q;

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Randomized scoreboard bench for pipe_rr_arbiter; burst rules are modelled when
// PIPE_RR_ARBITER_BURST_EN is defined.
module tb_pipe_rr_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic           stall = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_stall;
  logic [W-1:0]   data;
  logic           valid;
  logic [IW-1:0]  gid;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [IW-1:0] id;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model state: last granted index, expected output-register occupancy, burst lock.
  int    last_grant = N - 1;
  bit    m_valid = 1'b0;
  int    captured = -1;
  bit    locked = 1'b0;
  int    owner = 0;

  always #5 clk = ~clk;

  pipe_rr_arbiter #(.NUM_REQ(N), .DATA_W(W), .ID_W(IW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flush     (flush),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .i_req_last  (req_last),
    .o_req_stall (req_stall),
    .i_stall     (stall),
    .o_data      (data),
    .o_valid     (valid),
    .o_grant_id  (gid)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the head of the scoreboard must be the beat currently presented.
  always @(posedge clk) begin
    #3;
    if (rst_n) begin
      check("o_valid", 64'(valid), 64'(sb.size() != 0));
      if (valid && sb.size() != 0) begin
        check("o_data", 64'(data), 64'(sb[0].d));
        check("o_grant_id", 64'(gid), 64'(sb[0].id));
      end
      if (sb.size() != 0 && (!stall || flush)) void'(sb.pop_front());
    end
  end

  task automatic model_step();
    bit           ld;
    int           w;
    int           k;
    logic [N-1:0] exp_stall;
    beat_t        b;
    ld = (!m_valid || !stall) && !flush;
    w  = -1;
    if (locked) begin
      if (req_valid[owner]) w = owner;
    end else begin
      for (int off = 1; off <= N; off++) begin
        k = (last_grant + off) % N;
        if (w < 0 && req_valid[k]) w = k;
      end
    end
    exp_stall = '1;
    captured  = -1;
    if (ld && w >= 0) begin
      exp_stall[w] = 1'b0;
      captured     = w;
      b.d          = req_data[w*W +: W];
      b.id         = IW'(w);
      sb.push_back(b);
      last_grant   = w;
      m_valid      = 1'b1;
`ifdef PIPE_RR_ARBITER_BURST_EN
      if (!locked && !req_last[w]) begin
        locked = 1'b1;
        owner  = w;
      end else if (locked && req_last[w]) begin
        locked = 1'b0;
      end
`endif
    end else if (ld || flush) begin
      m_valid = 1'b0;
    end
    if (flush) locked = 1'b0;
    check("o_req_stall", 64'(req_stall), 64'(exp_stall));
  endtask

  // Requesters that offered a beat and were not captured keep it unchanged.
  task automatic drive(input int p_valid, input int p_stall, input int p_flush);
    for (int k = 0; k < N; k++) begin
      if (!(req_valid[k] && captured != k)) begin
        req_valid[k]       = ($urandom_range(99) < p_valid);
        req_data[k*W +: W] = W'($urandom);
        req_last[k]        = ($urandom_range(2) == 0);
      end
    end
    stall = ($urandom_range(99) < p_stall);
    flush = ($urandom_range(99) < p_flush);
  endtask

  task automatic run(input int cycles, input int p_valid, input int p_stall, input int p_flush);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      drive(p_valid, p_stall, p_flush);
      #3;
      model_step();
    end
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    stall     = 1'b0;
    flush     = 1'b0;
    #1;
    check("async_reset_valid", 64'(valid), 64'(0));
    check("async_reset_data", 64'(data), 64'(0));
    check("async_reset_gid", 64'(gid), 64'(0));
    sb.delete();
    m_valid    = 1'b0;
    last_grant = N - 1;
    locked     = 1'b0;
    captured   = -1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #2;
    check("reset_valid", 64'(valid), 64'(0));
    check("reset_data", 64'(data), 64'(0));
    check("reset_gid", 64'(gid), 64'(0));
    check("reset_stall", 64'(req_stall), 64'({N{1'b1}}));
    run(12, 100, 0, 0);
    run(200, 50, 30, 5);
    mid_reset();
    run(200, 70, 50, 3);
    run(100, 25, 10, 2);
    mid_reset();
    run(60, 100, 0, 0);
    run(100, 60, 20, 4);
    @(posedge clk);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
